// File: rtl/inverse_park_seq.sv
// Sequential inverse Park transform: (v_d, v_q) -> (v_alpha, v_beta) using Q1.15 sin/cos.
// One shared signed multiplier, four multiply steps per result, valid/ready on both sides.
//   alpha = cos*q + sin*d, beta = cos*d - sin*q, each floored by >>> FRAC and saturated.
module inverse_park_seq #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic signed [W-1:0] i_v_d,
    input  logic signed [W-1:0] i_v_q,
    input  logic signed [W-1:0] i_sin_theta,
    input  logic signed [W-1:0] i_cos_theta,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic signed [W-1:0] o_v_alpha,
    output logic signed [W-1:0] o_v_beta,
    output logic                o_sat
);

    typedef enum logic [2:0] {StIdle, StM0, StM1, StM2, StM3, StOut} state_e;

    // Clamp limits expressed at accumulator width
    localparam logic signed [2*W:0] MaxV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] MinV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    state_e              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic signed [W-1:0] r_d, r_q, r_sin, r_cos;
    logic signed [2*W:0] r_acc;
    logic signed [W-1:0] r_alpha_tmp;
    logic                r_sat_alpha;
    logic signed [W-1:0] r_v_alpha, r_v_beta;
    logic                r_sat;

    logic signed [W-1:0]   w_ma, w_mb;
    logic signed [2*W-1:0] w_prod;
    logic signed [2*W:0]   w_prod_ext;
    logic signed [2*W:0]   w_res;
    logic signed [2*W:0]   w_scaled;
    logic signed [W-1:0]   w_clip;
    logic                  w_clipped;

    // Operand select for the shared multiplier, one product per multiply state
    always_comb begin
        w_ma = r_cos;
        w_mb = r_q;
        case (r_state)
            StM0:    begin w_ma = r_cos; w_mb = r_q; end
            StM1:    begin w_ma = r_sin; w_mb = r_d; end
            StM2:    begin w_ma = r_cos; w_mb = r_d; end
            StM3:    begin w_ma = r_sin; w_mb = r_q; end
            default: begin w_ma = r_cos; w_mb = r_q; end
        endcase
    end

    // Multiply, combine with accumulator (add for alpha, subtract for beta), scale and clamp
    always_comb begin
        w_prod     = w_ma * w_mb;
        w_prod_ext = w_prod;
        w_res      = (r_state == StM3) ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
        w_scaled   = w_res >>> FRAC;
        w_clipped  = 1'b0;
        w_clip     = w_scaled[W-1:0];
        if (w_scaled > MaxV) begin
            w_clip    = MaxV[W-1:0];
            w_clipped = 1'b1;
        end else if (w_scaled < MinV) begin
            w_clip    = MinV[W-1:0];
            w_clipped = 1'b1;
        end
    end

    // Control FSM with datapath registers; outputs update only on entry to StOut
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_d         <= '0;
            r_q         <= '0;
            r_sin       <= '0;
            r_cos       <= '0;
            r_acc       <= '0;
            r_alpha_tmp <= '0;
            r_sat_alpha <= 1'b0;
            r_v_alpha   <= '0;
            r_v_beta    <= '0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_d        <= i_v_d;
                        r_q        <= i_v_q;
                        r_sin      <= i_sin_theta;
                        r_cos      <= i_cos_theta;
                        r_in_ready <= 1'b0;
                        r_state    <= StM0;
                    end
                end
                StM0: begin
                    r_acc   <= w_prod_ext;
                    r_state <= StM1;
                end
                StM1: begin
                    r_alpha_tmp <= w_clip;
                    r_sat_alpha <= w_clipped;
                    r_state     <= StM2;
                end
                StM2: begin
                    r_acc   <= w_prod_ext;
                    r_state <= StM3;
                end
                StM3: begin
                    r_v_alpha   <= r_alpha_tmp;
                    r_v_beta    <= w_clip;
                    r_sat       <= r_sat_alpha | w_clipped;
                    r_out_valid <= 1'b1;
                    r_state     <= StOut;
                end
                StOut: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_v_alpha   = r_v_alpha;
    assign o_v_beta    = r_v_beta;
    assign o_sat       = r_sat;

endmodule

// File: tb/tb_inverse_park_seq.sv
// Self-checking bench for inverse_park_seq: directed corner cases plus random vectors
// compared against an integer-arithmetic reference of the inverse Park transform.
module tb_inverse_park_seq;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] v_d = '0, v_q = '0, sin_t = '0, cos_t = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] v_alpha, v_beta;
    logic               sat;

    int n_cmp = 0;
    int n_err = 0;

    inverse_park_seq #(.W(16), .FRAC(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_v_d       (v_d),
        .i_v_q       (v_q),
        .i_sin_theta (sin_t),
        .i_cos_theta (cos_t),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_v_alpha   (v_alpha),
        .o_v_beta    (v_beta),
        .o_sat       (sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp16(input longint x, inout int s);
        if (x > 32767) begin s = 1; return 32767; end
        if (x < -32768) begin s = 1; return -32768; end
        return int'(x);
    endfunction

    // alpha = floor((cos*q + sin*d) / 2^15), beta = floor((cos*d - sin*q) / 2^15), clamped
    task automatic ref_model(input int d, input int q, input int s, input int c,
                             output int a, output int b, output int st);
        longint pa, pb;
        st = 0;
        pa = longint'(c) * q + longint'(s) * d;
        pb = longint'(c) * d - longint'(s) * q;
        pa = pa >>> 15;
        pb = pb >>> 15;
        a = clamp16(pa, st);
        b = clamp16(pb, st);
    endtask

    function automatic int rnd16();
        logic signed [15:0] t;
        case ($urandom_range(0, 7))
            0: t = 16'sh7FFF;
            1: t = 16'sh8000;
            default: t = 16'($urandom);
        endcase
        return int'(t);
    endfunction

    task automatic drive(input int d, input int q, input int s, input int c);
        v_d = 16'(d); v_q = 16'(q); sin_t = 16'(s); cos_t = 16'(c);
    endtask

    // One full transaction; hold = cycles out_ready stays low while in OUT
    task automatic do_txn(input string tag, input int d, input int q, input int s, input int c,
                          input int hold);
        int cnt, ea, eb, es;
        ref_model(d, q, s, c, ea, eb, es);
        cnt = 0;
        while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk({tag, ".ready_in"}, int'(in_ready), 1);
        out_ready = (hold == 0);
        drive(d, q, s, c);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(rnd16(), rnd16(), rnd16(), rnd16());
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            chk({tag, ".busy_in_ready"}, int'(in_ready), 0);
            @(posedge clk); #1; cnt++;
        end
        chk({tag, ".latency"}, cnt + 1, 5);
        chk({tag, ".alpha"}, int'(v_alpha), ea);
        chk({tag, ".beta"}, int'(v_beta), eb);
        chk({tag, ".sat"}, int'(sat), es);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            drive(rnd16(), rnd16(), rnd16(), rnd16());
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, int'(out_valid), 1);
            chk({tag, ".hold_ready_in"}, int'(in_ready), 0);
            chk({tag, ".hold_alpha"}, int'(v_alpha), ea);
            chk({tag, ".hold_beta"}, int'(v_beta), eb);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".drop_valid"}, int'(out_valid), 0);
        chk({tag, ".idle_ready"}, int'(in_ready), 1);
        chk({tag, ".retain_alpha"}, int'(v_alpha), ea);
    endtask

    initial begin
        int ea, eb, es, idx, last_cyc, cyc, nres, cnt;
        int vd[4], vq[4], vs[4], vc[4];
        int exp_a[$], exp_b[$], exp_s[$];

        // Reset state
        #3;
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.alpha", int'(v_alpha), 0);
        chk("rst.beta", int'(v_beta), 0);
        chk("rst.sat", int'(sat), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.in_ready", int'(in_ready), 1);

        // Directed cases
        do_txn("t1", 1000, 2000, 0, 32767, 0);
        do_txn("t2", 1000, -500, 32767, 0, 0);
        do_txn("t3p", 32767, 32767, 23170, 23170, 0);
        do_txn("t3n", -32768, -32768, 23170, 23170, 0);
        do_txn("t4", 1234, -4321, 12000, -20000, 10);

        // Back-to-back with in_valid held high: one result per 6 cycles, in order
        for (int k = 0; k < 4; k++) begin
            vd[k] = rnd16(); vq[k] = rnd16(); vs[k] = rnd16(); vc[k] = rnd16();
            ref_model(vd[k], vq[k], vs[k], vc[k], ea, eb, es);
            exp_a.push_back(ea); exp_b.push_back(eb); exp_s.push_back(es);
        end
        out_ready = 1'b1;
        idx = 0; nres = 0; last_cyc = -1;
        for (cyc = 0; cyc < 60 && nres < 4; cyc++) begin
            if (out_valid) begin
                chk("t5.alpha", int'(v_alpha), exp_a.pop_front());
                chk("t5.beta", int'(v_beta), exp_b.pop_front());
                chk("t5.sat", int'(sat), exp_s.pop_front());
                if (last_cyc >= 0) chk("t5.interval", cyc - last_cyc, 6);
                last_cyc = cyc;
                nres++;
            end
            if (in_ready && idx < 4) begin
                drive(vd[idx], vq[idx], vs[idx], vc[idx]);
                in_valid = 1'b1;
                idx++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("t5.count", nres, 4);
        repeat (8) @(posedge clk);
        #1;

        // Reset during M2 aborts and clears outputs
        drive(1000, 2000, 0, 32767);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6.out_valid", int'(out_valid), 0);
        chk("t6.alpha", int'(v_alpha), 0);
        chk("t6.beta", int'(v_beta), 0);
        chk("t6.sat", int'(sat), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6.in_ready", int'(in_ready), 1);
        do_txn("t6post", -1000, 3000, 16384, 28378, 0);

        // Random vectors with random back-pressure
        for (int k = 0; k < 25; k++) begin
            do_txn("rnd", rnd16(), rnd16(), rnd16(), rnd16(), int'($urandom_range(0, 3)));
        end

        cnt = n_err;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, cnt);
        $finish;
    end

endmodule
